// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// iteration count and iteration counter width.
package divider_pkg;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Execute-stage to divider connection: request operands, flush, and the
// {HI, LO} result with its completion pulse and pipeline stall request.
interface divider_if #(
  parameter int WIDTH = 32
) ();

  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               div_stall;

  modport master (
    output start, signed_div, annul, a, b,
    input  result, ready, div_stall
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output result, ready, div_stall
  );

endinterface

// File: rtl/divider_iter.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and record the quotient bit.
// The stored remainder is always below the divisor, so it fits in WIDTH bits;
// only the shifted value needs the extra bit.
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_shift_s;
  logic [WIDTH:0] d_ext_s;

  // Shift-compare-subtract for a single quotient bit.
  always_comb begin
    r_shift_s = {r_i, q_i[WIDTH-1]};
    d_ext_s   = {1'b0, d_i};
    if (r_shift_s >= d_ext_s) begin
      r_o = WIDTH'(r_shift_s - d_ext_s);
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = r_shift_s[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU. Works on operand
// magnitudes and fixes the signs of quotient and remainder on the final step.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  dif
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(WIDTH - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     bmag_q, bmag_d;
  logic                 sdiv_q, sdiv_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     r_n_s;
  logic [WIDTH-1:0]     q_n_s;
  logic                 ready_s;

  // Two's-complement negate when requested; the most negative value wraps to itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      cond_neg = -v;
    end else begin
      cond_neg = v;
    end
  endfunction

  divider_iter #(.WIDTH(WIDTH)) u_iter (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (bmag_q),
    .r_o (r_n_s),
    .q_o (q_n_s)
  );

  // Next-state and datapath updates; a flush always wins and leaves the result alone.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    bmag_d   = bmag_q;
    sdiv_d   = sdiv_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    if (dif.annul) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (dif.start) begin
            sdiv_d = dif.signed_div;
            sa_d   = dif.a[WIDTH-1];
            sb_d   = dif.b[WIDTH-1];
            q_d    = cond_neg(dif.a, dif.signed_div & dif.a[WIDTH-1]);
            bmag_d = cond_neg(dif.b, dif.signed_div & dif.b[WIDTH-1]);
            r_d    = {WIDTH{1'b0}};
            cnt_d  = {DIV_CNT_W{1'b0}};
            if (dif.b == {WIDTH{1'b0}}) begin
              state_d  = DIV_ZERO;
              result_d = {dif.a, {WIDTH{1'b1}}};
            end else begin
              state_d = DIV_BUSY;
            end
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          r_d   = r_n_s;
          q_d   = q_n_s;
          cnt_d = cnt_q + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_DONE;
            result_d = {cond_neg(r_n_s, sdiv_q & sa_q),
                        cond_neg(q_n_s, sdiv_q & (sa_q ^ sb_q))};
          end else begin
            state_d = DIV_BUSY;
          end
        end
        DIV_ZERO: state_d = DIV_IDLE;
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= {DIV_CNT_W{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      bmag_q   <= {WIDTH{1'b0}};
      sdiv_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      bmag_q   <= bmag_d;
      sdiv_q   <= sdiv_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  // Completion pulse in the presentation states, suppressed by a flush; stall until it.
  always_comb begin
    if ((state_q == DIV_DONE) || (state_q == DIV_ZERO)) begin
      ready_s = ~dif.annul;
    end else begin
      ready_s = 1'b0;
    end
    dif.ready     = ready_s;
    dif.div_stall = dif.start & ~ready_s;
    dif.result    = result_q;
  end

endmodule

// File: doc/divider.md
# divider

Iterative radix-2 restoring divider serving MIPS DIV/DIVU in the execute stage. It sits directly downstream of the ALU control decode: it is started when the decoded `alucontrol` equals `SIG_ALU_DIV` or `SIG_ALU_DIVU`. It holds the pipeline through a stall request until the 64-bit {remainder, quotient} result is ready for the HI/LO write.

## Interface
- `WIDTH`, 32: operand width. Result is 2*WIDTH; the iteration count equals WIDTH.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a divide. Held high by EX until `ready` is seen.
- `signed_div`  in  1  1 = DIV, 0 = DIVU. Sampled with `start`.
- `annul`  in  1  flush from exception/branch logic. Aborts the operation.
- `a`  in  WIDTH  dividend (rs). Sampled on the accepting edge.
- `b`  in  WIDTH  divisor (rt). Sampled on the accepting edge.
- `result`  out  2*WIDTH  {HI = remainder, LO = quotient}.
- `ready`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `div_stall`  out  1  combinational: `start & ~ready`.

## Operation
- States:
  - IDLE: no operation in progress.
  - BUSY: shift-subtract iterations running.
  - ZERO: divide-by-zero result cycle.
  - DONE: result presentation cycle.
- IDLE, `start`=1, `annul`=0:
  - Latch `signed_div` and the sign bits of a and b.
  - Latch |a| and |b| (two's-complement negate when signed and negative; unsigned operands are used as-is). Clear the 6-bit iteration counter.
  - If b==0, go to ZERO; otherwise go to BUSY.
- BUSY, each edge:
  - Partial remainder r (WIDTH+1 bits) = {r, q[MSB]}; quotient q shifts left.
  - If r >= |b|: r -= |b|, q[0] = 1.
  - Counter increments. When the counter reaches WIDTH-1, the state goes to DONE on that edge.
- DONE:
  - `ready`=1.
  - `result` = {rem, quo} after sign fix-up:
    - quotient negated if signed and sign(a) != sign(b);
    - remainder negated if signed and sign(a)=1.
  - Next edge goes to IDLE.
- ZERO:
  - `ready`=1.
  - `result` = {a, all-ones}; this is the chosen value for the architecturally undefined case.
  - Next edge goes to IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude path with WIDTH-bit wrap; no special case.
- `annul`:
  - In any state, the next edge goes to IDLE.
  - `ready` is forced 0 in the annulled cycle.
  - `result` register is not updated.
  - `annul` takes priority over `start` in the same cycle.
- `start` high in the cycle after `ready` is treated as a new operation; EX guarantees deassertion when advancing.
- `start` changes while BUSY are ignored; operands are not resampled.
- Reset values:
  - state = IDLE
  - `result` = 0
  - `ready` = 0
  - counter = 0
  - internal r and q = 0
- Reset mid-operation discards all progress immediately.

## Timing
- Edge E0 accepts `start`.
- Iterations run on E1..E32.
- `ready` and valid `result` occur in the cycle following E32 (33 cycles after the accept cycle).
- IDLE at E33.
- Divide by zero: `ready` in the cycle after E0.
- `div_stall` is combinational, high from the first `start` cycle through the cycle before `ready`, and low in the `ready` cycle.
- `result` is registered. It holds its value after DONE until the next completion.
- No combinational path from `a`/`b` to `result`.

## Structure
- Shared header `define_div.vh` holds:
  - state encodings DIV_IDLE, DIV_BUSY, DIV_ZERO, DIV_DONE (2 bits);
  - DIV_ITER = 32.
- The existing `define_alu_ctrl.vh` supplies SIG_ALU_DIV/DIVU for the EX-side start qualification.
- Natural sub-module: `div_iter`, a combinational single-step shift-compare-subtract cell (r, q, divisor in; r', q' out). It is instantiated once.

## Test plan
- DIVU 100 / 7: `ready` 33 cycles after accept; `result` = {0x00000002, 0x0000000E}; `div_stall` high for exactly 33 cycles.
- DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7 / -2: LO=0xFFFFFFFD, HI=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. DIVU same operands: LO=0, HI=0x80000000.
- DIVU 0x1234 / 0: `ready` in the cycle after accept; `result` = {0x00001234, 0xFFFFFFFF}.
- Annul at iteration 10: no `ready`; IDLE next cycle; `result` keeps its prior value. An immediate new DIVU 9 / 3 gives {0, 3} on schedule.
- Assert `rst` asynchronously mid-BUSY: state IDLE, `ready`=0, `result`=0 without a clock edge. A following DIVU 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
